cycle_sequencer: RTL and testbench
==================================

// Module: cycle_sequencer
// PURPOSE
//  Parametrised single-cycle micro-sequencer: program counter, program RAM, data RAM, accumulator.
//  Executes one instruction per clk while run=1 and not halted.
//  Adds conditional branching, halt/start control, output port and optional ALU on top of the
//  fixed 4-bit counter/RAM/Acc cycle machine. Sits between front-panel switches and the display logic.
// PARAMETERS
//  ADDR_WIDTH  4  program/data address width; both RAMs are 2**ADDR_WIDTH deep
//  DATA_WIDTH  4  accumulator / data RAM word width
//  localparam OPD_W = max(ADDR_WIDTH,DATA_WIDTH); INSTR_W = 4+OPD_W; instr = {op[3:0], opd[OPD_W-1:0]}
// PORTS
//  clk          in   1           rising-edge clock
//  reset_count  in   1           reset, asynchronous, active-high
//  run          in   1           1 = execute; 0 = freeze state, program loading allowed
//  start        in   1           1-cycle pulse: pc<=0, clear halted
//  prog_we      in   1           program RAM write strobe
//  prog_addr    in   ADDR_WIDTH  program RAM write address
//  prog_wdata   in   INSTR_W     program RAM write data
//  pc           out  ADDR_WIDTH  program counter
//  instr        out  INSTR_W     progmem[pc], combinational read
//  acc          out  DATA_WIDTH  accumulator
//  zero         out  1           acc==0, combinational
//  halted       out  1           HALT executed, sequencer stopped
//  out_data     out  DATA_WIDTH  output port register
//  out_valid    out  1           1-cycle pulse when out_data updated
// BEHAVIOUR
//  Reset (async): pc=0, acc=0, halted=0, out_data=0, out_valid=0 (so zero=1). RAM contents not reset.
//  step = run & ~halted & ~start. Each step: execute instr, pc<=pc+1 (wraps 2**ADDR_WIDTH-1 -> 0) unless jump.
//  Opcodes (opd truncated to ADDR_WIDTH for addresses, low DATA_WIDTH bits for immediates):
//   0 NOP; 1 LDI acc<=imm; 2 LD acc<=dmem[opd]; 3 ST dmem[opd]<=acc;
//   4 JMP pc<=opd; 5 JZ pc<=opd if acc==0 (pre-instruction acc) else pc+1;
//   6 OUT out_data<=acc, out_valid=1 next cycle only; 7 HALT halted<=1, pc holds at HALT address;
//   8 ADD / 9 SUB (see CONFIGURATION); 10-15 NOP.
//  Data RAM: async read, write on clk edge during ST step. LD of address just stored reads new value next step.
//  prog_we honoured only when run=0 or halted=1; ignored while stepping. Write visible on instr next cycle.
//  start: highest priority after reset; pc<=0, halted<=0, acc unchanged, no instruction executed that cycle.
//  run=0: all state holds; out_valid=0.
//  out_valid is 0 in every cycle not immediately following an OUT step.
//  Reset asserted mid-program: state cleared at once; execution resumes from pc=0 after release if run=1.
// CONFIGURATION
//  CYCLE_SEQ_ALU_EN defined: ADD acc<=acc+dmem[opd], SUB acc<=acc-dmem[opd], both modulo 2**DATA_WIDTH;
//   extra output carry (1 bit, reset 0) = carry-out of ADD / borrow of SUB, held otherwise;
//   opcode 11 JC: pc<=opd if carry=1.
//  Not defined: opcodes 8,9,11 execute as NOP; no carry port.
// TESTING
//  T1 reset mid-run: pc=5, acc=9, assert reset_count between edges -> pc=0, acc=0, zero=1, halted=0 at once.
//  T2 load {LDI 3, ST 2, LDI 0, LD 2, OUT, HALT}, run=1 -> out_data=3 with one out_valid pulse, halted=1, pc=5.
//  T3 loop {LDI 0, JZ 3, NOP, JMP 3}: pc sequence 0,1,3,3,3...; with LDI 1 at 0 -> 0,1,2,3,3.
//  T4 wrap: NOPs in all 16 slots -> pc 15 -> 0; start while halted -> pc=0 next edge, halted=0.
//  T5 prog_we while stepping -> RAM unchanged; same write with run=0 -> instr shows new word.
//  T6 (ALU_EN, DATA_WIDTH=4) dmem[1]=9, LDI 8, ADD 1 -> acc=1, carry=1; SUB 1 -> acc=8, carry=1; JC 0 taken.

Source files
------------

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer
// Purpose  : Single-cycle micro-sequencer built from a program counter, a
//            program RAM, a data RAM and an accumulator. It executes one
//            instruction per clock while run=1 and the sequencer is not
//            halted. Supports conditional branching, halt/start control and
//            an output port register. An optional ALU (ADD/SUB/JC plus a carry
//            flag) is enabled by defining the macro CYCLE_SEQ_ALU_EN.
// Ports    : clk, reset_count (async, active-high)
//            run        - 1 = execute, 0 = freeze (program loading allowed)
//            start      - 1-cycle pulse: pc<=0, clear halted
//            prog_we/prog_addr/prog_wdata - program RAM write port
//            pc, instr  - program counter and progmem[pc] (combinational)
//            acc, zero  - accumulator and acc==0 flag
//            halted     - HALT executed, sequencer stopped
//            out_data/out_valid - output port register and its update pulse
//            carry      - (CYCLE_SEQ_ALU_EN only) ADD carry / SUB borrow
// Revision : 1.0 - initial release
// ============================================================================
module cycle_sequencer #(
    parameter  int ADDR_WIDTH = 4,
    parameter  int DATA_WIDTH = 4,
    localparam int OPD_W      = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    localparam int INSTR_W    = 4 + OPD_W
) (
    input  logic                  clk,
    input  logic                  reset_count,
    input  logic                  run,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [INSTR_W-1:0]    prog_wdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [INSTR_W-1:0]    instr,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  zero,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
`ifdef CYCLE_SEQ_ALU_EN
    ,
    output logic                  carry
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [3:0] c_OP_LDI  = 4'd1;
    localparam logic [3:0] c_OP_LD   = 4'd2;
    localparam logic [3:0] c_OP_ST   = 4'd3;
    localparam logic [3:0] c_OP_JMP  = 4'd4;
    localparam logic [3:0] c_OP_JZ   = 4'd5;
    localparam logic [3:0] c_OP_OUT  = 4'd6;
    localparam logic [3:0] c_OP_HALT = 4'd7;
`ifdef CYCLE_SEQ_ALU_EN
    localparam logic [3:0] c_OP_ADD  = 4'd8;
    localparam logic [3:0] c_OP_SUB  = 4'd9;
    localparam logic [3:0] c_OP_JC   = 4'd11;
`endif

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  halted_q, halted_d;
    logic                  out_valid_q, out_valid_d;
`ifdef CYCLE_SEQ_ALU_EN
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
`endif

    logic [INSTR_W-1:0]    progmem [DEPTH];
    logic [DATA_WIDTH-1:0] dmem    [DEPTH];

    logic                  w_step;
    logic                  w_prog_wen;
    logic                  w_dmem_we;
    logic [3:0]            w_op;
    logic [OPD_W-1:0]      w_opd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_dmem_rd;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign instr      = progmem[pc_q];
    assign w_op       = instr[INSTR_W-1 -: 4];
    assign w_opd      = instr[OPD_W-1:0];
    assign w_addr     = w_opd[ADDR_WIDTH-1:0];
    assign w_imm      = w_opd[DATA_WIDTH-1:0];
    assign w_dmem_rd  = dmem[w_addr];
    assign w_pc_inc   = pc_q + ADDR_WIDTH'(1);

    // start steals the cycle: no instruction executes while it is high.
    assign w_step     = run & ~halted_q & ~start;
    // Program RAM is only writable when the sequencer is not stepping.
    assign w_prog_wen = prog_we & (~run | halted_q) & ~reset_count;

`ifdef CYCLE_SEQ_ALU_EN
    // The top bit of each result is the carry-out (ADD) or borrow (SUB).
    assign w_sum  = {1'b0, acc_q} + {1'b0, w_dmem_rd};
    assign w_diff = {1'b0, acc_q} - {1'b0, w_dmem_rd};
`endif

    always_comb begin
        pc_d        = pc_q;
        acc_d       = acc_q;
        halted_d    = halted_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        w_dmem_we   = 1'b0;
`ifdef CYCLE_SEQ_ALU_EN
        carry_d     = carry_q;
`endif
        if (start) begin
            pc_d     = '0;
            halted_d = 1'b0;
        end else if (w_step) begin
            pc_d = w_pc_inc;
            case (w_op)
                c_OP_LDI:  acc_d = w_imm;
                c_OP_LD:   acc_d = w_dmem_rd;
                c_OP_ST:   w_dmem_we = ~reset_count;
                c_OP_JMP:  pc_d = w_addr;
                c_OP_JZ:   if (acc_q == '0) pc_d = w_addr;
                c_OP_OUT: begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end
                c_OP_HALT: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
`ifdef CYCLE_SEQ_ALU_EN
                c_OP_ADD:  {carry_d, acc_d} = w_sum;
                c_OP_SUB:  {carry_d, acc_d} = w_diff;
                c_OP_JC:   if (carry_q) pc_d = w_addr;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            pc_q        <= '0;
            acc_q       <= '0;
            halted_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef CYCLE_SEQ_ALU_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            halted_q    <= halted_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef CYCLE_SEQ_ALU_EN
            carry_q     <= carry_d;
`endif
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_prog_wen) progmem[prog_addr] <= prog_wdata;
        if (w_dmem_we)  dmem[w_addr]       <= acc_q;
    end

    assign pc        = pc_q;
    assign acc       = acc_q;
    assign zero      = (acc_q == '0);
    assign halted    = halted_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef CYCLE_SEQ_ALU_EN
    assign carry     = carry_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_sequencer
// Purpose  : Self-checking bench for cycle_sequencer (default 4/4 widths).
//            An instruction-level model predicts architectural state each
//            cycle; OUT results go into a scoreboard queue that a separate
//            monitor drains whenever out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset_count;
    logic       run, start, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic [3:0] pc;
    logic [7:0] instr;
    logic [3:0] acc, out_data;
    logic       zero, halted, out_valid;
`ifdef CYCLE_SEQ_ALU_EN
    logic       carry;
`endif

    cycle_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
        .clk        (clk),
        .reset_count(reset_count),
        .run        (run),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .pc         (pc),
        .instr      (instr),
        .acc        (acc),
        .zero       (zero),
        .halted     (halted),
        .out_data   (out_data),
        .out_valid  (out_valid)
`ifdef CYCLE_SEQ_ALU_EN
        ,
        .carry      (carry)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    // Instruction-set level model state
    int m_pc, m_acc, m_halted, m_carry;
    int m_prog [16];
    int m_dmem [16];
    int sb [$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ins(input int op, input int opd);
        return op * 16 + opd;
    endfunction

    task automatic model_cycle(input bit r, input bit s, input bit we, input int wa, input int wd);
        int op, opd, nxt, was_halted;
        was_halted = m_halted;
        if (s) begin
            m_pc     = 0;
            m_halted = 0;
        end else if (r && m_halted == 0) begin
            op  = m_prog[m_pc] / 16;
            opd = m_prog[m_pc] % 16;
            nxt = (m_pc + 1) % 16;
            case (op)
                1: m_acc = opd;
                2: m_acc = m_dmem[opd];
                3: m_dmem[opd] = m_acc;
                4: nxt = opd;
                5: if (m_acc == 0) nxt = opd;
                6: sb.push_back(m_acc);
                7: begin m_halted = 1; nxt = m_pc; end
`ifdef CYCLE_SEQ_ALU_EN
                8: begin
                    m_carry = ((m_acc + m_dmem[opd]) > 15) ? 1 : 0;
                    m_acc   = (m_acc + m_dmem[opd]) % 16;
                end
                9: begin
                    m_carry = (m_acc < m_dmem[opd]) ? 1 : 0;
                    m_acc   = (m_acc - m_dmem[opd] + 16) % 16;
                end
                11: if (m_carry != 0) nxt = opd;
`endif
                default: ;
            endcase
            m_pc = nxt;
        end
        if (we && (!r || was_halted != 0)) m_prog[wa] = wd;
    endtask

    task automatic check_state(input bit with_instr);
        chk("pc", int'(pc), m_pc);
        chk("acc", int'(acc), m_acc);
        chk("halted", int'(halted), m_halted);
        chk("zero", int'(zero), (m_acc == 0) ? 1 : 0);
        if (with_instr) chk("instr", int'(instr), m_prog[m_pc]);
`ifdef CYCLE_SEQ_ALU_EN
        chk("carry", int'(carry), m_carry);
`endif
    endtask

    // One clock: drive at negedge, advance model, check after the edge.
    task automatic cyc(input bit r, input bit s, input bit we, input int wa, input int wd);
        @(negedge clk);
        run        = r;
        start      = s;
        prog_we    = we;
        prog_addr  = wa[3:0];
        prog_wdata = wd[7:0];
        model_cycle(r, s, we, wa, wd);
        @(posedge clk);
        #1;
        check_state(1'b1);
    endtask

    task automatic do_reset(input bit with_instr);
        run         = 1'b0;
        start       = 1'b0;
        prog_we     = 1'b0;
        reset_count = 1'b1;
        #1;
        m_pc = 0; m_acc = 0; m_halted = 0; m_carry = 0;
        sb.delete();
        check_state(with_instr);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(negedge clk);
        reset_count = 1'b0;
    endtask

    task automatic load(input int p [16]);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, i, p[i]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest OUT.
    always @(negedge clk) begin
        if (!reset_count && out_valid) begin
            n_pulse++;
            if (sb.size() == 0) chk("out_valid_unexpected", 1, 0);
            else                chk("out_data", int'(out_data), sb.pop_front());
        end
    end

    initial begin
        int p [16];
        int e1 [4];
        int e2 [4];
        int pulses0;

        run = 0; start = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0;
        reset_count = 1'b0;
        for (int i = 0; i < 16; i++) begin m_prog[i] = 0; m_dmem[i] = 0; end
        #2;
        do_reset(1'b0);

        // T1: reach pc=5 acc=9, then reset between edges
        for (int i = 0; i < 16; i++) p[i] = 0;
        p[0] = ins(1, 9);
        load(p);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        steps(5);
        chk("t1_pc_before", int'(pc), 5);
        chk("t1_acc_before", int'(acc), 9);
        #2;
        do_reset(1'b1);
        chk("t1_zero", int'(zero), 1);
        steps(1);
        chk("t1_resume_pc", int'(pc), 1);

        // T2: store/load/out/halt
        for (int i = 0; i < 16; i++) p[i] = 0;
        p[0] = ins(1, 3); p[1] = ins(3, 2); p[2] = ins(1, 0);
        p[3] = ins(2, 2); p[4] = ins(6, 0); p[5] = ins(7, 0);
        load(p);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        pulses0 = n_pulse;
        steps(8);
        chk("t2_out_data", int'(out_data), 3);
        chk("t2_pulses", n_pulse - pulses0, 1);
        chk("t2_halted", int'(halted), 1);
        chk("t2_pc", int'(pc), 5);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("t4_start_pc", int'(pc), 0);
        chk("t4_start_halted", int'(halted), 0);

        // T3: JZ loop, taken then not taken
        for (int i = 0; i < 16; i++) p[i] = 0;
        p[0] = ins(1, 0); p[1] = ins(5, 3); p[3] = ins(4, 3);
        load(p);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        e1 = '{1, 3, 3, 3};
        for (int i = 0; i < 4; i++) begin steps(1); chk("t3_jz_taken_pc", int'(pc), e1[i]); end
        cyc(1'b0, 1'b0, 1'b1, 0, ins(1, 1));
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        e2 = '{1, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin steps(1); chk("t3_jz_not_pc", int'(pc), e2[i]); end

        // T4: wrap with all NOPs
        for (int i = 0; i < 16; i++) p[i] = 0;
        load(p);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        steps(15);
        chk("t4_pc15", int'(pc), 15);
        steps(1);
        chk("t4_wrap", int'(pc), 0);

        // T5: program writes ignored while stepping, honoured with run=0
        cyc(1'b1, 1'b0, 1'b1, 2, ins(1, 7));
        steps(1);
        chk("t5_ignored", int'(instr), 0);
        cyc(1'b0, 1'b0, 1'b1, 2, ins(1, 7));
        chk("t5_written", int'(instr), ins(1, 7));

`ifdef CYCLE_SEQ_ALU_EN
        // T6: ADD/SUB carry and JC
        for (int i = 0; i < 16; i++) p[i] = 0;
        p[0] = ins(1, 9); p[1] = ins(3, 1); p[2] = ins(1, 8);
        p[3] = ins(8, 1); p[4] = ins(9, 1); p[5] = ins(11, 0);
        load(p);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        steps(4);
        chk("t6_add_acc", int'(acc), 1);
        chk("t6_add_carry", int'(carry), 1);
        steps(1);
        chk("t6_sub_acc", int'(acc), 8);
        chk("t6_sub_carry", int'(carry), 1);
        steps(1);
        chk("t6_jc_pc", int'(pc), 0);
`endif

        // Fill data RAM with known random values in two passes
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                p[2*i]   = ins(1, int'($urandom_range(0, 15)));
                p[2*i+1] = ins(3, pass * 8 + i);
            end
            load(p);
            cyc(1'b1, 1'b1, 1'b0, 0, 0);
            steps(16);
        end

        // Random programs with random run/start/write activity
        for (int rnd = 0; rnd < 8; rnd++) begin
            for (int i = 0; i < 16; i++) p[i] = int'($urandom_range(0, 255));
            load(p);
            cyc(1'b1, 1'b1, 1'b0, 0, 0);
            for (int c = 0; c < 80; c++) begin
                cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)));
            end
        end

        // Drain: any pending OUT pulse must have been observed
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
